decoder_stage_seq: RTL and testbench

- Parametrised successor to the decoder's one-bit stage progression.
- Buffers fetched 16-bit instructions in a small FIFO and presents the head instruction to the scheduler.
- Sequences each instruction through a configurable number of pre-stages followed by one normal stage. Pre-stages are used by call forms to push pc + n.
- Adds queue depth, flush on taken jump, and multi-cycle pre-stage counts; the single-bit stage register could do none of these.

---
 rtl/decoder_stage_seq.sv | 92 +++++++++
 tb/tb_decoder_stage_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stage_seq.sv
// Instruction queue plus stage sequencer: call forms get extra pre-stages before the normal stage.
// Pushed words reach the head one cycle later; when full, in_ready drops and pushes are ignored.
module decoder_stage_seq #(
  parameter int         DEPTH           = 2,
  parameter int         CALL_PRE_STAGES = 1,
  parameter logic [3:0] CC_CALL         = 4'hF,
  parameter int         STAGE_BITS      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [15:0]              in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     inst_valid,
  output logic [15:0]              inst,
  output logic [STAGE_BITS-1:0]    stage_idx,
  output logic                     pre_stage,
  output logic                     normal_stage,
  input  logic                     sc_inst_done,
  output logic                     inst_done,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int                    AW       = $clog2(DEPTH);
  localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [STAGE_BITS-1:0] N_CALL   = STAGE_BITS'(CALL_PRE_STAGES);

  logic [15:0]           mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [STAGE_BITS-1:0] stage_q;
  logic [15:0]           head;
  logic                  is_call;
  logic [STAGE_BITS-1:0] n_pre;
  logic                  last_stage;
  logic                  push;
  logic                  pop;

  assign in_ready   = (count != FULL_CNT);
  assign inst_valid = (count != '0);
  assign fill_count = count;
  assign stage_idx  = stage_q;

  // Empty queue presents a zero word so classification never sees stale storage.
  assign head = inst_valid ? mem[rd_ptr] : 16'h0000;
  assign inst = head;

  assign is_call = inst_valid &&
                   (((head[15:12] == 4'b0000) && (head[11:8] == CC_CALL)) ||
                    (head[15:6] == 10'b0010000001));
  assign n_pre        = is_call ? N_CALL : '0;
  assign last_stage   = (stage_q == n_pre);
  assign pre_stage    = (stage_q < n_pre);
  assign normal_stage = !pre_stage;
  assign inst_done    = inst_valid && sc_inst_done && last_stage;

  assign push = in_valid && in_ready;
  assign pop  = inst_done;

  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stage_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        stage_q <= '0;
      end else if (sc_inst_done && inst_valid && !last_stage) begin
        stage_q <= stage_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_stage_seq.sv
// Directed bench: vector table on a CALL_PRE_STAGES=1 instance, hand sequences on a CALL_PRE_STAGES=2 instance.
module tb_decoder_stage_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_inst;
  logic        flush;
  logic        sc_inst_done;

  logic        in_ready1, inst_valid1, pre_stage1, normal_stage1, inst_done1;
  logic [15:0] inst1;
  logic [2:0]  stage_idx1;
  logic [1:0]  fill_count1;

  logic        in_ready2, inst_valid2, pre_stage2, normal_stage2, inst_done2;
  logic [15:0] inst2;
  logic [2:0]  stage_idx2;
  logic [1:0]  fill_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_stage_seq #(.DEPTH(2), .CALL_PRE_STAGES(1), .CC_CALL(4'hF), .STAGE_BITS(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready1),
    .flush(flush), .inst_valid(inst_valid1), .inst(inst1), .stage_idx(stage_idx1),
    .pre_stage(pre_stage1), .normal_stage(normal_stage1), .sc_inst_done(sc_inst_done),
    .inst_done(inst_done1), .fill_count(fill_count1)
  );

  decoder_stage_seq #(.DEPTH(2), .CALL_PRE_STAGES(2), .CC_CALL(4'hF), .STAGE_BITS(3)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready2),
    .flush(flush), .inst_valid(inst_valid2), .inst(inst2), .stage_idx(stage_idx2),
    .pre_stage(pre_stage2), .normal_stage(normal_stage2), .sc_inst_done(sc_inst_done),
    .inst_done(inst_done2), .fill_count(fill_count2)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        s;
    logic        e_valid;
    logic [15:0] e_inst;
    logic [2:0]  e_stage;
    logic        e_pre;
    logic        e_done;
    logic [1:0]  e_fill;
    logic        e_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic f, input logic s);
    in_valid     = v;
    in_inst      = d;
    flush        = f;
    sc_inst_done = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string nm, input logic e_valid, input logic [15:0] e_inst,
                      input logic [2:0] e_stage, input logic e_pre, input logic e_done,
                      input logic [1:0] e_fill, input logic e_rdy);
    chk({nm, "_valid"},  inst_valid2,   e_valid);
    chk({nm, "_inst"},   inst2,         e_inst);
    chk({nm, "_stage"},  stage_idx2,    e_stage);
    chk({nm, "_pre"},    pre_stage2,    e_pre);
    chk({nm, "_normal"}, normal_stage2, !e_pre);
    chk({nm, "_done"},   inst_done2,    e_done);
    chk({nm, "_fill"},   fill_count2,   e_fill);
    chk({nm, "_rdy"},    in_ready2,     e_rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    // v, d, f, s | valid, inst, stage, pre, done, fill, rdy  (expected before the edge)
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b1, 16'h8123, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8123, 3'd0, 1'b0, 1'b1, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    // call src with one pre-stage
    vq.push_back('{1'b1, 16'h2040, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2040, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2040, 3'd1, 1'b0, 1'b1, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    // fill to full; pushes while full are dropped even with a same-cycle pop
    vq.push_back('{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1});
    vq.push_back('{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h1111, 3'd0, 1'b0, 1'b0, 2'd2, 1'b0});
    vq.push_back('{1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 16'h1111, 3'd0, 1'b0, 1'b1, 2'd2, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2222, 3'd0, 1'b0, 1'b1, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    // flush in stage 1 of a call with two queued
    vq.push_back('{1'b1, 16'h2040, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h2040, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2040, 3'd0, 1'b1, 1'b0, 2'd2, 1'b0});
    vq.push_back('{1'b1, 16'h6666, 1'b1, 1'b0, 1'b1, 16'h2040, 3'd1, 1'b0, 1'b0, 2'd2, 1'b0});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    // flush drops a push that would otherwise be accepted
    vq.push_back('{1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    vq.push_back('{1'b1, 16'h8888, 1'b1, 1'b0, 1'b1, 16'h7777, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    // streaming: push and pop every cycle, pointers wrap several times
    vq.push_back('{1'b1, 16'hA001, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});
    for (int k = 1; k < 8; k++) begin
      vq.push_back('{1'b1, 16'hA001 + 16'(k), 1'b0, 1'b1, 1'b1, 16'hA000 + 16'(k),
                     3'd0, 1'b0, 1'b1, 2'd1, 1'b1});
    end
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA008, 3'd0, 1'b0, 1'b1, 2'd1, 1'b1});
    vq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1});

    do_reset();
    chk("rst_valid",  inst_valid1,   1'b0);
    chk("rst_inst",   inst1,         16'h0000);
    chk("rst_fill",   fill_count1,   2'd0);
    chk("rst_stage",  stage_idx1,    3'd0);
    chk("rst_rdy",    in_ready1,     1'b1);
    chk("rst_pre",    pre_stage1,    1'b0);
    chk("rst_normal", normal_stage1, 1'b1);
    chk("rst_done",   inst_done1,    1'b0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].d, vq[i].f, vq[i].s);
      #1;
      chk($sformatf("v%0d_valid", i),  inst_valid1,   vq[i].e_valid);
      chk($sformatf("v%0d_inst", i),   inst1,         vq[i].e_inst);
      chk($sformatf("v%0d_stage", i),  stage_idx1,    vq[i].e_stage);
      chk($sformatf("v%0d_pre", i),    pre_stage1,    vq[i].e_pre);
      chk($sformatf("v%0d_normal", i), normal_stage1, !vq[i].e_pre);
      chk($sformatf("v%0d_done", i),   inst_done1,    vq[i].e_done);
      chk($sformatf("v%0d_fill", i),   fill_count1,   vq[i].e_fill);
      chk($sformatf("v%0d_rdy", i),    in_ready1,     vq[i].e_rdy);
      tick();
    end

    // Call branch with two pre-stages: three scheduler pulses to retire.
    do_reset();
    reset = 1'b0;
    drive(1'b1, 16'h0F10, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    #1;
    chk2("cb_s0", 1'b1, 16'h0F10, 3'd0, 1'b1, 1'b0, 2'd1, 1'b1);
    tick();
    chk2("cb_s1", 1'b1, 16'h0F10, 3'd1, 1'b1, 1'b0, 2'd1, 1'b1);
    tick();
    chk2("cb_s2", 1'b1, 16'h0F10, 3'd2, 1'b0, 1'b1, 2'd1, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    chk2("cb_end", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1);

    // Reset while in a pre-stage returns to the reset state.
    drive(1'b1, 16'h0F10, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    chk2("mid_pre", 1'b1, 16'h0F10, 3'd1, 1'b1, 1'b0, 2'd1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk2("mid_rst", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
